// File: rtl/celement_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : celement_rx_pkg
// Brief   : Shared types and constants for the C-element pipeline receiver.
// Revision: 1.0 - initial release
// ============================================================================
package celement_rx_pkg;

   localparam int DW_DEFAULT          = 8;
   localparam int DEPTH_DEFAULT       = 4;
   localparam int SYNC_STAGES_DEFAULT = 2;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   // ACKH is the only state with bit 1 set, so the acknowledge is a single flop bit
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CAPT = 2'b01,
      ACKH = 2'b10
   } chan_state_e;

endpackage
`default_nettype wire

// File: rtl/celement_rx_chan.sv
`default_nettype none
// ============================================================================
// Module  : celement_rx_chan
// Brief   : One 4-phase SEND/ACK channel: SEND synchronizer, bundled-data
//           holding register and IDLE/CAPT/ACKH handshake FSM.
// Revision: 1.0 - initial release
// ============================================================================
module celement_rx_chan
   import celement_rx_pkg::*;
#(
   parameter int DW          = DW_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          send,
   input  logic [DW-1:0] din,
   output logic          ack,
   output logic          wr_req,
   input  logic          wr_gnt,
   output logic [DW-1:0] data
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_ssend;
   chan_state_e            r_state;
   chan_state_e            w_next;
   logic [DW-1:0]          r_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], send};
      end
   end

   assign w_ssend = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_ssend) w_next = CAPT;
         CAPT:    if (wr_gnt)  w_next = ACKH;
         ACKH:    if (!w_ssend) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      ack    = (r_state == ACKH);
      wr_req = (r_state == CAPT);
   end

   // Bundled data is stable while SEND is high, so capture on the IDLE->CAPT edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
      end else if ((r_state == IDLE) && w_ssend) begin
         r_data <= din;
      end
   end

   assign data = r_data;

   // Upstream may not withdraw SEND before it has been acknowledged
   a_send_held_in_capt : assert property (
      @(posedge clk) disable iff (rst) (r_state == CAPT) |-> w_ssend
   );

endmodule
`default_nettype wire

// File: rtl/celement_sync_merge_rx.sv
`default_nettype none
// ============================================================================
// Module  : celement_sync_merge_rx
// Brief   : Clocked receiver merging the main and copy C-element channels
//           through a round-robin arbiter into a valid/ready FIFO.
//           Optional TOKCNT output with macro CELEMENT_RX_TOKCNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module celement_sync_merge_rx
   import celement_rx_pkg::*;
#(
   parameter int DW          = DW_DEFAULT,
   parameter int DEPTH       = DEPTH_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          SENDIN_A,
   input  logic [DW-1:0] DATAIN_A,
   output logic          ACKOUT_A,
   input  logic          SENDIN_B,
   input  logic [DW-1:0] DATAIN_B,
   output logic          ACKOUT_B,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic [DW-1:0] OUT_DATA,
   output logic          OUT_SRC,
   output logic          FULL
`ifdef CELEMENT_RX_TOKCNT_EN
   ,
   output logic [15:0]   TOKCNT
`endif
);

   localparam int c_AW = $clog2(DEPTH);

   logic          w_req_a, w_req_b;
   logic          w_gnt_a, w_gnt_b;
   logic [DW-1:0] w_data_a, w_data_b;
   logic          w_wr, w_pop, w_full, w_empty;
   logic          w_wsrc;
   logic [DW-1:0] w_wdata;
   logic          r_rr;
   logic [c_AW:0] r_wr_ptr, r_rd_ptr;
   logic [DW:0]   r_mem [DEPTH];

   celement_rx_chan #(
      .DW          (DW),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_chan_a (
      .clk    (CLK),
      .rst    (RESET),
      .send   (SENDIN_A),
      .din    (DATAIN_A),
      .ack    (ACKOUT_A),
      .wr_req (w_req_a),
      .wr_gnt (w_gnt_a),
      .data   (w_data_a)
   );

   celement_rx_chan #(
      .DW          (DW),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_chan_b (
      .clk    (CLK),
      .rst    (RESET),
      .send   (SENDIN_B),
      .din    (DATAIN_B),
      .ack    (ACKOUT_B),
      .wr_req (w_req_b),
      .wr_gnt (w_gnt_b),
      .data   (w_data_b)
   );

   // FULL comes from registered pointers, so a same-cycle pop cannot free a slot
   assign w_gnt_a = !w_full && w_req_a && (!w_req_b || (r_rr == SRC_A));
   assign w_gnt_b = !w_full && w_req_b && (!w_req_a || (r_rr == SRC_B));
   assign w_wr    = w_gnt_a || w_gnt_b;
   assign w_wsrc  = w_gnt_b ? SRC_B : SRC_A;
   assign w_wdata = w_gnt_b ? w_data_b : w_data_a;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_rr <= SRC_A;
      end else if (w_wr) begin
         r_rr <= w_gnt_a ? SRC_B : SRC_A;
      end
   end

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_pop   = !w_empty && OUT_READY;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= {w_wsrc, w_wdata};
      end
   end

   assign OUT_VALID           = !w_empty;
   assign {OUT_SRC, OUT_DATA} = r_mem[r_rd_ptr[c_AW-1:0]];
   assign FULL                = w_full;

`ifdef CELEMENT_RX_TOKCNT_EN
   logic [15:0] r_tokcnt;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_tokcnt <= '0;
      end else if (w_wr) begin
         r_tokcnt <= r_tokcnt + 16'd1;
      end
   end

   assign TOKCNT = r_tokcnt;
`else
   // Token counter not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_celement_sync_merge_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_celement_sync_merge_rx
// Brief   : Directed self-checking bench for celement_sync_merge_rx
//           (TOKCNT checks built with CELEMENT_RX_TOKCNT_EN).
// Revision: 1.0 - initial release
// ============================================================================
module tb_celement_sync_merge_rx;

   logic       clk;
   logic       rst;
   logic       send_a, send_b;
   logic [7:0] din_a, din_b;
   logic       ack_a, ack_b;
   logic       out_valid, out_ready, out_src, full;
   logic [7:0] out_data;
`ifdef CELEMENT_RX_TOKCNT_EN
   logic [15:0] tokcnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   celement_sync_merge_rx #(
      .DW          (8),
      .DEPTH       (4),
      .SYNC_STAGES (2)
   ) dut (
      .CLK       (clk),
      .RESET     (rst),
      .SENDIN_A  (send_a),
      .DATAIN_A  (din_a),
      .ACKOUT_A  (ack_a),
      .SENDIN_B  (send_b),
      .DATAIN_B  (din_b),
      .ACKOUT_B  (ack_b),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready),
      .OUT_DATA  (out_data),
      .OUT_SRC   (out_src),
      .FULL      (full)
`ifdef CELEMENT_RX_TOKCNT_EN
      ,
      .TOKCNT    (tokcnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic cur_ack(input bit ch);
      return ch ? ack_b : ack_a;
   endfunction

   task automatic do_reset;
      rst       = 1'b1;
      send_a    = 1'b0;
      send_b    = 1'b0;
      din_a     = '0;
      din_b     = '0;
      out_ready = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   // Full 4-phase handshake on one channel, with bounded waits on ACK
   task automatic send_tok(input bit ch, input logic [7:0] d);
      int i;
      if (ch) begin din_b = d; send_b = 1'b1; end
      else    begin din_a = d; send_a = 1'b1; end
      i = 0;
      while (!cur_ack(ch) && i < 40) begin tick(1); i++; end
      check_eq("tok_ack_rise", cur_ack(ch), 1);
      if (ch) send_b = 1'b0; else send_a = 1'b0;
      i = 0;
      while (cur_ack(ch) && i < 40) begin tick(1); i++; end
      check_eq("tok_ack_fall", cur_ack(ch), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int i;

      // Reset values
      do_reset();
      check_eq("rst_ack_a", ack_a, 0);
      check_eq("rst_ack_b", ack_b, 0);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_src", out_src, 0);
      check_eq("rst_full", full, 0);

      // Single token: visible after the fourth edge, ACK drops three edges after SEND falls
      out_ready = 1'b1;
      din_a     = 8'h5A;
      send_a    = 1'b1;
      tick(3);
      check_eq("t1_valid_e3", out_valid, 0);
      check_eq("t1_ack_e3", ack_a, 0);
      tick(1);
      check_eq("t1_valid_e4", out_valid, 1);
      check_eq("t1_data", out_data, 8'h5A);
      check_eq("t1_src", out_src, 0);
      check_eq("t1_ack_e4", ack_a, 1);
      send_a = 1'b0;
      tick(1);
      check_eq("t1_popped", out_valid, 0);
      tick(1);
      check_eq("t1_ack_hold", ack_a, 1);
      tick(1);
      check_eq("t1_ack_drop", ack_a, 0);
`ifdef CELEMENT_RX_TOKCNT_EN
      check_eq("t1_tokcnt", tokcnt, 16'd1);
`endif

      // Simultaneous pair from reset: pointer favours A
      do_reset();
      out_ready = 1'b1;
      din_a = 8'h11; din_b = 8'h22;
      send_a = 1'b1; send_b = 1'b1;
      tick(4);
      check_eq("p1_data0", out_data, 8'h11);
      check_eq("p1_src0", out_src, 0);
      check_eq("p1_ack_a", ack_a, 1);
      check_eq("p1_ack_b_wait", ack_b, 0);
      tick(1);
      check_eq("p1_data1", out_data, 8'h22);
      check_eq("p1_src1", out_src, 1);
      check_eq("p1_ack_b", ack_b, 1);
      send_a = 1'b0; send_b = 1'b0;
      tick(5);
      check_eq("p1_acks_low", {ack_a, ack_b}, 0);
      // A lone A grant leaves the pointer on B for the next pair
      send_tok(1'b0, 8'h30);
      din_a = 8'h33; din_b = 8'h44;
      send_a = 1'b1; send_b = 1'b1;
      tick(4);
      check_eq("p2_data0", out_data, 8'h44);
      check_eq("p2_src0", out_src, 1);
      check_eq("p2_ack_a_wait", ack_a, 0);
      tick(1);
      check_eq("p2_data1", out_data, 8'h33);
      check_eq("p2_src1", out_src, 0);
      send_a = 1'b0; send_b = 1'b0;
      tick(5);

      // FULL backpressure
      do_reset();
      for (int k = 1; k <= 4; k++) send_tok(1'b0, 8'(k));
      check_eq("f_full", full, 1);
      check_eq("f_head", out_data, 8'h01);
      din_a = 8'h05; send_a = 1'b1;
      tick(6);
      check_eq("f_blocked_ack", ack_a, 0);
      check_eq("f_still_full", full, 1);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check_eq("f_pop_full", full, 0);
      check_eq("f_pop_ack", ack_a, 0);
      check_eq("f_pop_head", out_data, 8'h02);
      tick(1);
      check_eq("f_wr_ack", ack_a, 1);
      check_eq("f_refull", full, 1);
      send_a = 1'b0;
      i = 0;
      while (ack_a && i < 40) begin tick(1); i++; end
      check_eq("f_ack_fall", ack_a, 0);
      out_ready = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         check_eq("f_drain_valid", out_valid, 1);
         check_eq("f_drain_data", out_data, 8'(k));
         tick(1);
      end
      check_eq("f_drained", out_valid, 0);

      // Pop and write in the same cycle at occupancy 2
      do_reset();
      send_tok(1'b0, 8'h21);
      send_tok(1'b0, 8'h22);
      din_a = 8'h23; send_a = 1'b1;
      tick(3);
      check_eq("pw_capt_ack", ack_a, 0);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check_eq("pw_ack", ack_a, 1);
      check_eq("pw_head", out_data, 8'h22);
      check_eq("pw_full", full, 0);
      send_a = 1'b0;
      tick(5);
      out_ready = 1'b1;
      check_eq("pw_d0", out_data, 8'h22);
      tick(1);
      check_eq("pw_d1", out_data, 8'h23);
      check_eq("pw_v1", out_valid, 1);
      tick(1);
      check_eq("pw_empty", out_valid, 0);

      // Asynchronous reset while a channel sits in ACKH with three entries queued
      do_reset();
      send_tok(1'b0, 8'h31);
      send_tok(1'b0, 8'h32);
      din_a = 8'h33; send_a = 1'b1;
      i = 0;
      while (!ack_a && i < 40) begin tick(1); i++; end
      check_eq("ar_ackh", ack_a, 1);
      check_eq("ar_valid_pre", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("ar_ack_now", ack_a, 0);
      check_eq("ar_valid_now", out_valid, 0);
      check_eq("ar_data_now", out_data, 0);
      send_a = 1'b0;
      tick(1);
      rst = 1'b0;
      out_ready = 1'b1;
      din_a = 8'h5C; send_a = 1'b1;
      tick(3);
      check_eq("ar_lat_e3", out_valid, 0);
      tick(1);
      check_eq("ar_lat_e4", out_valid, 1);
      check_eq("ar_lat_data", out_data, 8'h5C);
      check_eq("ar_lat_ack", ack_a, 1);
`ifdef CELEMENT_RX_TOKCNT_EN
      check_eq("ar_tokcnt", tokcnt, 16'd1);
`endif
      send_a = 1'b0;
      tick(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
